// File: rtl/text_pkg.sv
// text_pkg: shared constants, pipeline bundle type and address helper
// for the text-mode pixel generator.
package text_pkg;

    localparam int COLS    = 80;
    localparam int ROWS    = 30;
    localparam int CHAR_W  = 8;
    localparam int CHAR_H  = 8;
    localparam int LAT     = 4;
    localparam int TRAM_AW = 12;
    localparam int CHR_AW  = 11;

    // Per-pixel state carried alongside the memory lookups
    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic       blank;
        logic [2:0] x;
        logic [2:0] y;
    } pix_pipe_t;

    localparam int PIPE_W = $bits(pix_pipe_t);

    // Linear text RAM address of a character cell
    function automatic logic [TRAM_AW-1:0] cell_addr(
        input logic [5:0] row,
        input logic [6:0] col,
        input int         cols
    );
        return TRAM_AW'(row) * TRAM_AW'(cols) + TRAM_AW'(col);
    endfunction

endpackage

// File: rtl/text_pixel_gen_pipe_delay.sv
// pipe_delay: W-bit wide, D-stage delay line with synchronous
// active-high reset of every stage to zero.
module pipe_delay #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_tap [D];

    // Shift register; every tap cleared on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                r_tap[i] <= '0;
            end
        end else begin
            r_tap[0] <= i_d;
            for (int i = 1; i < D; i++) begin
                r_tap[i] <= r_tap[i-1];
            end
        end
    end

    assign o_q = r_tap[D-1];

endmodule

// File: rtl/text_pixel_gen.sv
// text_pixel_gen: text RAM -> char ROM -> 1-bit pixel, fixed 4-cycle latency.
// Define TEXT_CURSOR_EN for a blinking underline cursor.
module text_pixel_gen #(
    parameter int COLS       = text_pkg::COLS,
    parameter int ROWS       = text_pkg::ROWS,
    parameter int BLINK_LOG2 = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        de_in,
    input  logic                        hs_in,
    input  logic                        vs_in,
    input  logic [9:0]                  x,
    input  logic [9:0]                  y,
    output logic [text_pkg::TRAM_AW-1:0] tram_ad,
    output logic                        tram_ce,
    input  logic [7:0]                  tram_dout,
    output logic [text_pkg::CHR_AW-1:0] chr_ad,
    output logic                        chr_ce,
    output logic                        chr_oce,
    input  logic [7:0]                  chr_dout,
    output logic                        pix,
    output logic                        de_out,
    output logic                        hs_out,
    output logic                        vs_out
`ifdef TEXT_CURSOR_EN
    ,
    input  logic [6:0]                  cursor_col,
    input  logic [4:0]                  cursor_row
`endif
);

    import text_pkg::*;

    logic [6:0]         w_col;
    logic [5:0]         w_row;
    logic               w_blank0;
    pix_pipe_t          w_s0;
    pix_pipe_t          w_s2;
    pix_pipe_t          w_s3;
    logic               w_cur3;
    logic               w_glyph_bit;
    logic [TRAM_AW-1:0] r_tram_ad;
    logic               r_pix;
    logic               r_de;
    logic               r_hs;
    logic               r_vs;

    assign w_col = x[9:3];
    assign w_row = y[8:3];

    // y[9] set means y >= 512, always off-screen
    assign w_blank0 = !de_in
                   || (int'(w_col) >= COLS)
                   || (int'(w_row) >= ROWS)
                   || y[9];

    // Bundle entering the delay line
    always_comb begin
        w_s0       = '0;
        w_s0.de    = de_in;
        w_s0.hs    = hs_in;
        w_s0.vs    = vs_in;
        w_s0.blank = w_blank0;
        w_s0.x     = x[2:0];
        w_s0.y     = y[2:0];
    end

    // Stage 1: text RAM address, forced to zero for blank cells
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tram_ad <= '0;
        end else if (w_blank0) begin
            r_tram_ad <= '0;
        end else begin
            r_tram_ad <= cell_addr(w_row, w_col, COLS);
        end
    end

    assign tram_ad = r_tram_ad;
    assign tram_ce = !reset;
    assign chr_ce  = !reset;
    assign chr_oce = 1'b1;

    // Two stages: lines up y with tram_dout for the ROM address
    pipe_delay #(
        .W (PIPE_W),
        .D (2)
    ) u_dly_s2 (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_s0),
        .o_q   (w_s2)
    );

    // One more stage: lines up x and blank with chr_dout
    pipe_delay #(
        .W (PIPE_W),
        .D (1)
    ) u_dly_s3 (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_s2),
        .o_q   (w_s3)
    );

    // Stage 2: ROM address straight from the text RAM output
    assign chr_ad = reset ? '0 : {tram_dout, w_s2.y};

`ifdef TEXT_CURSOR_EN
    logic [BLINK_LOG2:0] r_frame;
    logic                r_vs_prev;
    logic                w_phase;
    logic                w_cur0;

    // Frame counter advances on each vsync rising edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame   <= '0;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_prev <= vs_in;
            if (vs_in && !r_vs_prev) begin
                r_frame <= r_frame + 1'b1;
            end
        end
    end

    // Each blink phase lasts 2^BLINK_LOG2 frames
    assign w_phase = r_frame[BLINK_LOG2];

    // Underline covers the bottom two glyph rows of the cursor cell
    assign w_cur0 = w_phase
                 && (w_col == cursor_col)
                 && (w_row == {1'b0, cursor_row})
                 && (y[2:1] == 2'b11);

    pipe_delay #(
        .W (1),
        .D (3)
    ) u_dly_cur (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_cur0),
        .o_q   (w_cur3)
    );
`else
    assign w_cur3 = 1'b0;
`endif

    // Pick the glyph bit; MSB is the leftmost pixel
    assign w_glyph_bit = chr_dout[3'd7 - w_s3.x];

    // Stage 3: pixel and delayed syncs; de gating keeps flushed slots dark
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix <= 1'b0;
            r_de  <= 1'b0;
            r_hs  <= 1'b0;
            r_vs  <= 1'b0;
        end else begin
            r_pix <= w_s3.de && !w_s3.blank && (w_cur3 || w_glyph_bit);
            r_de  <= w_s3.de;
            r_hs  <= w_s3.hs;
            r_vs  <= w_s3.vs;
        end
    end

    assign pix    = r_pix;
    assign de_out = r_de;
    assign hs_out = r_hs;
    assign vs_out = r_vs;

endmodule

// File: tb/tb_text_pixel_gen.sv
// tb_text_pixel_gen: directed vector table plus sync-pulse,
// mid-frame reset and (with TEXT_CURSOR_EN) cursor blink sequences.
module tb_text_pixel_gen;

    import text_pkg::*;

    typedef struct {
        logic        de;
        logic        hs;
        logic        vs;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] tram;
        logic [10:0] chr;
        logic        pix;
    } vec_t;

    localparam int NV = 16;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        de_in     = 1'b1;
    logic        hs_in     = 1'b1;
    logic        vs_in     = 1'b1;
    logic [9:0]  x         = 10'd17;
    logic [9:0]  y         = 10'd35;
    logic [11:0] tram_ad;
    logic        tram_ce;
    logic [7:0]  tram_dout = 8'h00;
    logic [10:0] chr_ad;
    logic        chr_ce;
    logic        chr_oce;
    logic [7:0]  chr_dout  = 8'h00;
    logic        pix;
    logic        de_out;
    logic        hs_out;
    logic        vs_out;
    logic        glyph_zero = 1'b0;
`ifdef TEXT_CURSOR_EN
    logic [6:0]  cursor_col = 7'd2;
    logic [4:0]  cursor_row = 5'd4;
`endif

    int checks   = 0;
    int failures = 0;

    vec_t vecs [NV];

    text_pixel_gen dut (
        .clk        (clk),
        .reset      (reset),
        .de_in      (de_in),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .x          (x),
        .y          (y),
        .tram_ad    (tram_ad),
        .tram_ce    (tram_ce),
        .tram_dout  (tram_dout),
        .chr_ad     (chr_ad),
        .chr_ce     (chr_ce),
        .chr_oce    (chr_oce),
        .chr_dout   (chr_dout),
        .pix        (pix),
        .de_out     (de_out),
        .hs_out     (hs_out),
        .vs_out     (vs_out)
`ifdef TEXT_CURSOR_EN
        ,
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
`endif
    );

    always #5 clk = ~clk;

    // Text RAM contents: cell 322 holds 'A', cell 0 holds 0xFF
    function automatic logic [7:0] tram_fn(input logic [11:0] a);
        if (a == 12'd322) return 8'h41;
        if (a == 12'd0)   return 8'hFF;
        return 8'h20;
    endfunction

    // Character ROM: 'A' rows are 0x30, code 0xFF is solid
    function automatic logic [7:0] chr_fn(input logic [10:0] a);
        logic [7:0] code;
        code = a[10:3];
        if (glyph_zero)     return 8'h00;
        if (code == 8'h41)  return 8'h30;
        if (code == 8'hFF)  return 8'hFF;
        return 8'h00;
    endfunction

    // Synchronous memories, one cycle read latency
    always @(posedge clk) begin
        tram_dout <= tram_fn(tram_ad);
        chr_dout  <= chr_fn(chr_ad);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic de, input logic hs,
                                input logic vs, input int xi, input int yi,
                                input int tr, input int ch, input logic p);
        vec_t v;
        v.de   = de;
        v.hs   = hs;
        v.vs   = vs;
        v.x    = 10'(xi);
        v.y    = 10'(yi);
        v.tram = 12'(tr);
        v.chr  = 11'(ch);
        v.pix  = p;
        return v;
    endfunction

    task automatic idle();
        de_in = 1'b0;
        hs_in = 1'b1;
        vs_in = 1'b1;
        x     = '0;
        y     = '0;
    endtask

`ifdef TEXT_CURSOR_EN
    task automatic vs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            vs_in = 1'b1;
            tick();
            vs_in = 1'b0;
            tick();
        end
    endtask

    task automatic cell_run(input int y0, input logic expv);
        for (int i = 0; i < 12; i++) begin
            if (i >= LAT) begin
                chk($sformatf("cur_y%0d_x%0d", y0, 16 + i - LAT), pix, expv);
            end
            if (i < 8) begin
                de_in = 1'b1;
                x     = 10'(16 + i);
                y     = 10'(y0);
            end else begin
                de_in = 1'b0;
            end
            tick();
        end
    endtask
`endif

    initial begin
        int hs_low, hs_first, vs_low, vs_first, de_hi, de_first;

        // cell (col 2,row 4) 'A' row 3 = 0x30 across x=16..23
        vecs[0]  = mk(1, 1, 1,  16,  35,  322, 'h20B, 0);
        vecs[1]  = mk(1, 1, 1,  17,  35,  322, 'h20B, 0);
        vecs[2]  = mk(1, 0, 1,  18,  35,  322, 'h20B, 1);
        vecs[3]  = mk(1, 0, 1,  19,  35,  322, 'h20B, 1);
        vecs[4]  = mk(1, 1, 0,  20,  35,  322, 'h20B, 0);
        vecs[5]  = mk(1, 1, 0,  21,  35,  322, 'h20B, 0);
        vecs[6]  = mk(1, 1, 1,  22,  35,  322, 'h20B, 0);
        vecs[7]  = mk(1, 1, 1,  23,  35,  322, 'h20B, 0);
        // blank cases: address 0 returns solid glyph, pix must stay 0
        vecs[8]  = mk(0, 0, 1,  16,  35,    0, 'h7FB, 0);
        vecs[9]  = mk(1, 1, 1, 640,  35,    0, 'h7FB, 0);
        vecs[10] = mk(1, 1, 0, 700, 480,    0, 'h7F8, 0);
        // cell 0 is on-screen and solid
        vecs[11] = mk(1, 1, 1,   3,   5,    0, 'h7FD, 1);
        vecs[12] = mk(1, 1, 1, 639, 100, 1039, 'h104, 0);
        vecs[13] = mk(1, 0, 1,   8, 239, 2321, 'h107, 0);
        vecs[14] = mk(1, 1, 1,   8, 240,    0, 'h7F8, 0);
        vecs[15] = mk(1, 1, 1,   0,   7,    0, 'h7FF, 1);

        // reset with active inputs
        tick();
        tick();
        tick();
        chk("rst_pix",     pix,     1'b0);
        chk("rst_de_out",  de_out,  1'b0);
        chk("rst_hs_out",  hs_out,  1'b0);
        chk("rst_vs_out",  vs_out,  1'b0);
        chk("rst_tram_ce", tram_ce, 1'b0);
        chk("rst_chr_ce",  chr_ce,  1'b0);
        chk("rst_tram_ad", tram_ad, 12'd0);
        chk("rst_chr_ad",  chr_ad,  11'd0);
        chk("chr_oce",     chr_oce, 1'b1);

        reset = 1'b0;
        idle();
        for (int i = 0; i < 6; i++) tick();
        chk("run_tram_ce", tram_ce, 1'b1);
        chk("run_chr_ce",  chr_ce,  1'b1);

        // vector table: address at +1, ROM address at +2, pixel at +4
        for (int j = 0; j < NV + LAT; j++) begin
            if (j >= 1 && j - 1 < NV) begin
                chk($sformatf("v%0d_tram_ad", j - 1), tram_ad, vecs[j-1].tram);
            end
            if (j >= 2 && j - 2 < NV) begin
                chk($sformatf("v%0d_chr_ad", j - 2), chr_ad, vecs[j-2].chr);
            end
            if (j >= LAT) begin
                chk($sformatf("v%0d_pix", j - LAT), pix, vecs[j-LAT].pix);
                chk($sformatf("v%0d_syncs", j - LAT), {de_out, hs_out, vs_out},
                    {vecs[j-LAT].de, vecs[j-LAT].hs, vecs[j-LAT].vs});
            end
            if (j < NV) begin
                de_in = vecs[j].de;
                hs_in = vecs[j].hs;
                vs_in = vecs[j].vs;
                x     = vecs[j].x;
                y     = vecs[j].y;
            end else begin
                idle();
            end
            tick();
        end

        // sync pulse widths: hs low 10..105, vs low 20..115, de high 30..69
        hs_low   = 0;
        hs_first = -1;
        vs_low   = 0;
        vs_first = -1;
        de_hi    = 0;
        de_first = -1;
        for (int k = 0; k < 140; k++) begin
            if (!hs_out) begin
                hs_low++;
                if (hs_first < 0) hs_first = k;
            end
            if (!vs_out) begin
                vs_low++;
                if (vs_first < 0) vs_first = k;
            end
            if (de_out) begin
                de_hi++;
                if (de_first < 0) de_first = k;
            end
            hs_in = !(k >= 10 && k <= 105);
            vs_in = !(k >= 20 && k <= 115);
            de_in = (k >= 30 && k <= 69);
            x     = 10'd100;
            y     = 10'd100;
            tick();
        end
        chk("hs_low_width", hs_low,   96);
        chk("hs_low_start", hs_first, 14);
        chk("vs_low_width", vs_low,   96);
        chk("vs_low_start", vs_first, 24);
        chk("de_hi_width",  de_hi,    40);
        chk("de_hi_start",  de_first, 34);

        // mid-frame reset on a lit pixel
        de_in = 1'b1;
        hs_in = 1'b1;
        vs_in = 1'b1;
        x     = 10'd18;
        y     = 10'd35;
        for (int i = 0; i < 6; i++) tick();
        chk("mf_pre_pix",   pix, 1'b1);
        chk("mf_pre_syncs", {de_out, hs_out, vs_out}, 3'b111);
        reset = 1'b1;
        tick();
        chk("mf_rst_pix",   pix, 1'b0);
        chk("mf_rst_syncs", {de_out, hs_out, vs_out}, 3'b000);
        chk("mf_rst_tram",  tram_ad, 12'd0);
        tick();
        reset = 1'b0;
        for (int m = 1; m <= LAT; m++) begin
            tick();
            if (m < LAT) begin
                chk($sformatf("mf_flush%0d", m), {pix, de_out, hs_out}, 3'b000);
            end else begin
                chk("mf_resume", {pix, de_out, hs_out}, 3'b111);
            end
        end

`ifdef TEXT_CURSOR_EN
        // cursor at (2,4), blank glyphs so only the underline lights
        glyph_zero = 1'b1;
        de_in      = 1'b0;
        vs_in      = 1'b0;
        tick();
        vs_pulses(32);
        cell_run(38, 1'b1);
        cell_run(39, 1'b1);
        cell_run(37, 1'b0);
        vs_pulses(32);
        cell_run(38, 1'b0);
        cell_run(39, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
